// File: rtl/vga_frame_scheduler_if.sv
// Bundles the pixel tick, the raster outputs and the updater handshake of vga_frame_scheduler.
// master: the scheduler itself; slave: the pixel-clock divider / renderer / SNES updater side.
interface vga_frame_scheduler_if;
   logic       pix_en;
   logic [9:0] h_count;
   logic [9:0] v_count;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       frame_start;
   logic       upd_req;
   logic       upd_done;
   logic       upd_grant;
   logic       upd_abort;

   modport master (
      input  pix_en, upd_req, upd_done,
      output h_count, v_count, hsync, vsync, video_on, frame_start, upd_grant, upd_abort
   );

   modport slave (
      output pix_en, upd_req, upd_done,
      input  h_count, v_count, hsync, vsync, video_on, frame_start, upd_grant, upd_abort
   );
endinterface

// File: rtl/vga_frame_scheduler.sv
// VGA raster sequencer plus vertical-blank arbiter for the shared sprite-position registers.
// The updater may only own the registers between the last visible line and the guard lines,
// so the renderer never sees a half-written sprite.
module vga_frame_scheduler #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int GUARD_LINES = 2
) (
   input logic                   clock,
   input logic                   reset,
   vga_frame_scheduler_if.master bus
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] WIN_END  = 10'(V_TOTAL - GUARD_LINES);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_GRANT = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   logic [9:0] r_h_count;
   logic [9:0] r_v_count;
   logic       r_frame_start;
   logic [1:0] r_state;
   logic       r_grant;
   logic       r_abort;

   logic       w_h_last;
   logic       w_v_last;
   logic       w_window;
   logic [1:0] w_state_nxt;
   logic       w_abort_nxt;

   assign w_h_last = (r_h_count == H_LAST);
   assign w_v_last = (r_v_count == V_LAST);
   // Update window: vertical blank minus the trailing guard lines.
   assign w_window = (r_v_count >= V_VIS) && (r_v_count < WIN_END);

   // Raster counters advance on the pixel tick; the line counter steps on each line wrap.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_h_count <= '0;
         r_v_count <= '0;
      end else if (bus.pix_en) begin
         if (w_h_last) begin
            r_h_count <= '0;
            r_v_count <= w_v_last ? 10'd0 : r_v_count + 10'd1;
         end else begin
            r_h_count <= r_h_count + 10'd1;
         end
      end
   end

   // Frame pulse lands in the same clock the counters first read (0,0) after a full-frame wrap.
   always_ff @(posedge clock) begin
      if (reset) r_frame_start <= 1'b0;
      else       r_frame_start <= bus.pix_en && w_h_last && w_v_last;
   end

   // Arbiter next-state: one grant per request, done beats a simultaneous window close.
   always_comb begin
      w_state_nxt = r_state;
      w_abort_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.upd_req) w_state_nxt = w_window ? ST_GRANT : ST_ARMED;
         end
         ST_ARMED: begin
            if (!bus.upd_req)  w_state_nxt = ST_IDLE;
            else if (w_window) w_state_nxt = ST_GRANT;
         end
         ST_GRANT: begin
            if (bus.upd_done) begin
               w_state_nxt = ST_HOLD;
            end else if (!bus.upd_req) begin
               w_state_nxt = ST_IDLE;
            end else if (!w_window) begin
               w_state_nxt = ST_IDLE;
               w_abort_nxt = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!bus.upd_req) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Arbiter state and registered grant/abort outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_grant <= 1'b0;
         r_abort <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= (w_state_nxt == ST_GRANT);
         r_abort <= w_abort_nxt;
      end
   end

   assign bus.h_count     = r_h_count;
   assign bus.v_count     = r_v_count;
   assign bus.hsync       = ~((r_h_count >= HS_FIRST) && (r_h_count <= HS_LAST));
   assign bus.vsync       = ~((r_v_count >= VS_FIRST) && (r_v_count <= VS_LAST));
   assign bus.video_on    = (r_h_count < H_VIS) && (r_v_count < V_VIS);
   assign bus.frame_start = r_frame_start;
   assign bus.upd_grant   = r_grant;
   assign bus.upd_abort   = r_abort;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench for vga_frame_scheduler.
// u_big runs the full 800x525 timing for the first line only; u_dut uses a shrunken raster
// (16 px x 12 lines: hsync low h=10..12, vsync low v=7..8, window v=6..9, guard v=10..11)
// so whole frames and the vertical-blank arbitration fit in a short run.
module tb_vga_frame_scheduler;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   int   fs_cnt, fs_bad, hs_lo, hs_bad, vs_lo, vs_bad, vid_cnt;

   vga_frame_scheduler_if s_if ();
   vga_frame_scheduler_if b_if ();

   vga_frame_scheduler #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
      .GUARD_LINES(2)
   ) u_dut (
      .clock(clk),
      .reset(rst),
      .bus  (s_if)
   );

   vga_frame_scheduler u_big (
      .clock(clk),
      .reset(rst),
      .bus  (b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance the small raster with a pixel tick every clock until it reads (th,tv).
   task automatic run_to(input logic [9:0] th, input logic [9:0] tv);
      int n;
      n = 0;
      while (!(s_if.h_count == th && s_if.v_count == tv) && n < 1000) begin
         s_if.pix_en = 1'b1;
         tick();
         n++;
      end
      chk("run_to_bound", 32'(n < 1000), 1);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      fs_cnt = 0; fs_bad = 0; hs_lo = 0; hs_bad = 0; vs_lo = 0; vs_bad = 0; vid_cnt = 0;
      rst = 1'b1;
      s_if.pix_en = 1'b0; s_if.upd_req = 1'b0; s_if.upd_done = 1'b0;
      b_if.pix_en = 1'b0; b_if.upd_req = 1'b0; b_if.upd_done = 1'b0;
      tick(); tick();

      // Reset state
      chk("rst_h",        32'(s_if.h_count), 0);
      chk("rst_v",        32'(s_if.v_count), 0);
      chk("rst_fs",       32'(s_if.frame_start), 0);
      chk("rst_grant",    32'(s_if.upd_grant), 0);
      chk("rst_abort",    32'(s_if.upd_abort), 0);
      chk("rst_hsync",    32'(s_if.hsync), 1);
      chk("rst_vsync",    32'(s_if.vsync), 1);
      chk("rst_video_on", 32'(s_if.video_on), 1);
      rst = 1'b0;

      // Full-size first line: hsync low 656..751, video_on off from 640, wrap to line 1
      b_if.pix_en = 1'b1;
      for (int k = 1; k <= 800; k++) begin
         tick();
         case (k)
            639: chk("big_vid_639",  32'(b_if.video_on), 1);
            640: chk("big_vid_640",  32'(b_if.video_on), 0);
            655: chk("big_hs_655",   32'(b_if.hsync), 1);
            656: chk("big_hs_656",   32'(b_if.hsync), 0);
            751: chk("big_hs_751",   32'(b_if.hsync), 0);
            752: chk("big_hs_752",   32'(b_if.hsync), 1);
            799: chk("big_h_799",    32'(b_if.h_count), 799);
            800: begin
               chk("big_wrap_h", 32'(b_if.h_count), 0);
               chk("big_wrap_v", 32'(b_if.v_count), 1);
               chk("big_no_fs",  32'(b_if.frame_start), 0);
            end
            default: ;
         endcase
      end
      b_if.pix_en = 1'b0;
      chk("frozen_h", 32'(s_if.h_count), 0);
      chk("frozen_v", 32'(s_if.v_count), 0);

      // T1: pixel tick every 2nd clock for two full frames
      for (int c = 0; c < 768; c++) begin
         s_if.pix_en = (c % 2 == 0);
         tick();
         if (s_if.frame_start) begin
            fs_cnt++;
            if (s_if.h_count != 10'd0 || s_if.v_count != 10'd0) fs_bad++;
         end
         if (!s_if.hsync) begin
            hs_lo++;
            if (s_if.h_count < 10'd10 || s_if.h_count > 10'd12) hs_bad++;
         end
         if (!s_if.vsync) begin
            vs_lo++;
            if (s_if.v_count < 10'd7 || s_if.v_count > 10'd8) vs_bad++;
         end
         if (s_if.video_on) vid_cnt++;
      end
      s_if.pix_en = 1'b0;
      chk("t1_fs_count",  32'(fs_cnt), 2);
      chk("t1_fs_place",  32'(fs_bad), 0);
      chk("t1_hs_count",  32'(hs_lo), 144);
      chk("t1_hs_place",  32'(hs_bad), 0);
      chk("t1_vs_count",  32'(vs_lo), 128);
      chk("t1_vs_place",  32'(vs_bad), 0);
      chk("t1_vid_count", 32'(vid_cnt), 192);
      chk("t1_end_h",     32'(s_if.h_count), 0);
      chk("t1_end_v",     32'(s_if.v_count), 0);

      // T2: request early in the frame, grant one clock after line 6 starts, done releases
      s_if.upd_req = 1'b1;
      run_to(10'd0, 10'd6);
      chk("t2_grant_pre",  32'(s_if.upd_grant), 0);
      tick();
      chk("t2_grant_rise", 32'(s_if.upd_grant), 1);
      chk("t2_no_abort",   32'(s_if.upd_abort), 0);
      run_to(10'd0, 10'd7);
      chk("t2_grant_held", 32'(s_if.upd_grant), 1);
      s_if.upd_done = 1'b1;
      tick();
      s_if.upd_done = 1'b0;
      chk("t2_done_rel",   32'(s_if.upd_grant), 0);
      tick(); tick(); tick();
      chk("t2_hold",       32'(s_if.upd_grant), 0);
      s_if.upd_req = 1'b0;
      tick();
      chk("t2_idle",       32'(s_if.upd_grant), 0);
      s_if.upd_req = 1'b1;
      tick();
      chk("t2_regrant",    32'(s_if.upd_grant), 1);

      // T3: request held without done -> abort when the guard lines begin
      run_to(10'd0, 10'd10);
      chk("t3_grant_last", 32'(s_if.upd_grant), 1);
      chk("t3_abort_pre",  32'(s_if.upd_abort), 0);
      tick();
      chk("t3_grant_fall", 32'(s_if.upd_grant), 0);
      chk("t3_abort",      32'(s_if.upd_abort), 1);
      tick();
      chk("t3_abort_1clk", 32'(s_if.upd_abort), 0);
      chk("t3_no_grant",   32'(s_if.upd_grant), 0);
      run_to(10'd0, 10'd6);
      chk("t3_armed_wait", 32'(s_if.upd_grant), 0);
      tick();
      chk("t3_next_grant", 32'(s_if.upd_grant), 1);
      s_if.upd_req = 1'b0;
      tick();
      chk("t3_drop_grant", 32'(s_if.upd_grant), 0);
      chk("t3_drop_abort", 32'(s_if.upd_abort), 0);

      // T4: request raised in a guard line waits for the next window; done at close -> no abort
      run_to(10'd0, 10'd10);
      s_if.upd_req = 1'b1;
      tick();
      chk("t4_guard_nogr", 32'(s_if.upd_grant), 0);
      run_to(10'd0, 10'd0);
      chk("t4_wrap_nogr",  32'(s_if.upd_grant), 0);
      run_to(10'd0, 10'd6);
      chk("t4_l6_nogr",    32'(s_if.upd_grant), 0);
      tick();
      chk("t4_grant",      32'(s_if.upd_grant), 1);
      run_to(10'd0, 10'd10);
      chk("t4_grant_l10",  32'(s_if.upd_grant), 1);
      s_if.upd_done = 1'b1;
      tick();
      s_if.upd_done = 1'b0;
      chk("t4_done_nogr",  32'(s_if.upd_grant), 0);
      chk("t4_done_noab",  32'(s_if.upd_abort), 0);
      s_if.upd_req = 1'b0;
      tick();

      // T5: reset pulse in the middle of a grant
      s_if.upd_req = 1'b1;
      run_to(10'd0, 10'd8);
      chk("t5_grant_pre",  32'(s_if.upd_grant), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_grant",      32'(s_if.upd_grant), 0);
      chk("t5_h",          32'(s_if.h_count), 0);
      chk("t5_v",          32'(s_if.v_count), 0);
      chk("t5_fs",         32'(s_if.frame_start), 0);
      chk("t5_abort",      32'(s_if.upd_abort), 0);

      // T6: pixel tick stalled during a grant; done still releases next clock
      run_to(10'd0, 10'd6);
      s_if.pix_en = 1'b0;
      tick();
      chk("t6_grant",      32'(s_if.upd_grant), 1);
      for (int k = 0; k < 48; k++) tick();
      chk("t6_frozen_h",   32'(s_if.h_count), 0);
      chk("t6_frozen_v",   32'(s_if.v_count), 6);
      chk("t6_still_gr",   32'(s_if.upd_grant), 1);
      s_if.upd_done = 1'b1;
      tick();
      s_if.upd_done = 1'b0;
      chk("t6_release",    32'(s_if.upd_grant), 0);
      chk("t6_h_after",    32'(s_if.h_count), 0);
      chk("t6_v_after",    32'(s_if.v_count), 6);
      chk("t6_no_abort",   32'(s_if.upd_abort), 0);
      s_if.upd_req = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
